div_seq: RTL and testbench

//  Iterative signed/unsigned 32-bit divide sequencer for the EXM stage; replaces the u_div instance.

---
 rtl/div_seq.sv | 122 ++++++++++++
 tb/tb_div_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Iterative restoring divider (signed/unsigned) for the EXM stage, one quotient bit per cycle.
// Optional DIV_ZERO_FAST_EN: a zero divisor finishes one edge after the load instead of running WIDTH steps.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             use_mod,
    input  logic             adv,
    output logic [WIDTH-1:0] div_result,
    output logic             div_ok,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo;       // dividend shifts out the top while quotient bits shift in
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] x_raw;
    logic             sgn, mod, x_neg, y_neg, y_zero;

    logic             load, finish, fast_zero;
    logic [WIDTH:0]   rem_shift, trial, rem_next;
    logic [WIDTH-1:0] quo_next, q_fix, r_fix, final_res, x_abs, y_abs;
    logic             step_ok;

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = y_zero;
`else
    assign fast_zero = 1'b0;
`endif

    assign x_abs = (div_signed && x[WIDTH-1]) ? -x : x;
    assign y_abs = (div_signed && y[WIDTH-1]) ? -y : y;

    // One restoring step: shift in the next dividend bit, keep the subtraction if it did not borrow.
    assign rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvs};
    assign step_ok   = ~trial[WIDTH];
    assign rem_next  = step_ok ? trial : rem_shift;
    assign quo_next  = {quo[WIDTH-2:0], step_ok};

    assign q_fix     = (sgn && (x_neg ^ y_neg)) ? -quo_next : quo_next;
    assign r_fix     = (sgn && x_neg) ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
    assign final_res = y_zero ? (mod ? x_raw : '1) : (mod ? r_fix : q_fix);

    assign busy   = (state == BUSY);
    assign div_ok = ~div | (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block is given a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        finish    = 1'b0;
        if (!div) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    load      = 1'b1;
                    state_nxt = BUSY;
                end
                BUSY: begin
                    if (cnt == CW'(WIDTH-1) || fast_zero) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end
                end
                DONE: if (adv) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            quo        <= '0;
            dvs        <= '0;
            rem        <= '0;
            x_raw      <= '0;
            sgn        <= 1'b0;
            mod        <= 1'b0;
            x_neg      <= 1'b0;
            y_neg      <= 1'b0;
            y_zero     <= 1'b0;
            div_result <= '0;
        end else if (load) begin
            cnt    <= '0;
            quo    <= x_abs;
            dvs    <= y_abs;
            rem    <= '0;
            x_raw  <= x;
            sgn    <= div_signed;
            mod    <= use_mod;
            x_neg  <= div_signed & x[WIDTH-1];
            y_neg  <= div_signed & y[WIDTH-1];
            y_zero <= (y == '0);
        end else if (state == BUSY && div) begin
            cnt <= cnt + 1'b1;
            quo <= quo_next;
            rem <= rem_next;
            if (finish) div_result <= final_res;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Randomized self-checking bench for div_seq against a plain-arithmetic reference model.
// Honors DIV_ZERO_FAST_EN for the expected divide-by-zero latency.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset, div, div_signed, use_mod, adv;
    logic [31:0] x, y, div_result;
    logic        div_ok, busy;

    int n_tests = 0;
    int n_fail  = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .div(div), .div_signed(div_signed),
        .x(x), .y(y), .use_mod(use_mod), .adv(adv),
        .div_result(div_result), .div_ok(div_ok), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input bit sg, input bit md);
        longint p, d, q, r;
        if (b == 0) return md ? a : 32'hFFFF_FFFF;
        if (sg) begin
            p = longint'($signed(a));
            d = longint'($signed(b));
        end else begin
            p = longint'({32'b0, a});
            d = longint'({32'b0, b});
        end
        q = p / d;
        r = p % d;
        return md ? r[31:0] : q[31:0];
    endfunction

    function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 0) return 2;
`endif
        return 33;
    endfunction

    // Issue one divide, wait for div_ok (bounded), hold in DONE, then advance. Ends idle with div=0.
    task automatic do_div(input string tag, input logic [31:0] xi, input logic [31:0] yi,
                          input bit sg, input bit md, input int hold, input bit scramble);
        logic [31:0] exp;
        int n;
        exp        = ref_div(xi, yi, sg, md);
        x          = xi;
        y          = yi;
        div_signed = sg;
        use_mod    = md;
        adv        = 1'b0;
        div        = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (scramble) begin
                x = $urandom;
                y = $urandom;
                div_signed = 1'($urandom);
                use_mod    = 1'($urandom);
            end
            if (div_ok) begin n = i; break; end
        end
        check({tag, " latency"}, n, exp_latency(yi));
        check({tag, " result"}, div_result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold ok"}, {31'b0, div_ok}, 32'd1);
            check({tag, " hold val"}, div_result, exp);
        end
        adv = 1'b1;
        @(posedge clk); #1;
        adv = 1'b0;
        check({tag, " idle busy"}, {31'b0, busy}, 32'd0);
        div = 1'b0;
    endtask

    initial begin
        logic [31:0] rx, ry;
        reset = 1'b1; div = 1'b0; div_signed = 1'b0; use_mod = 1'b0; adv = 1'b0;
        x = '0; y = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset result", div_result, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset div_ok", {31'b0, div_ok}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        do_div("u 100/7 q", 32'd100, 32'd7, 1'b0, 1'b0, 0, 1'b0);
        do_div("u 100/7 r", 32'd100, 32'd7, 1'b0, 1'b1, 0, 1'b0);
        do_div("s -7/2 q", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0, 1'b0);
        do_div("s -7/2 r", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 0, 1'b0);
        do_div("s ovf q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b0);
        do_div("s ovf r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, 1'b0);
        do_div("u dz q", 32'h1234, 32'd0, 1'b0, 1'b0, 0, 1'b0);
        do_div("u dz r", 32'h1234, 32'd0, 1'b0, 1'b1, 0, 1'b0);
        do_div("s dz r", 32'hFFFF_8000, 32'd0, 1'b1, 1'b1, 0, 1'b0);
        do_div("s 7/-2 q", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 0, 1'b0);
        do_div("done hold", 32'd1000, 32'd9, 1'b0, 1'b0, 5, 1'b0);

        // Abort at step 10, then a fresh request must finish at full latency with its own result.
        x = 32'd100; y = 32'd7; div_signed = 1'b0; use_mod = 1'b0; div = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        check("abort busy before", {31'b0, busy}, 32'd1);
        check("abort div_ok before", {31'b0, div_ok}, 32'd0);
        div = 1'b0;
        @(posedge clk); #1;
        check("abort busy after", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        do_div("after abort 20/3", 32'd20, 32'd3, 1'b0, 1'b0, 0, 1'b0);

        // Asynchronous reset at step 5 clears result and state without a clock edge.
        x = 32'd5000; y = 32'd3; div = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid reset result", div_result, 32'd0);
        check("mid reset busy", {31'b0, busy}, 32'd0);
        #1;
        reset = 1'b0;
        div   = 1'b0;
        @(posedge clk); #1;
        do_div("after reset", 32'd5000, 32'd3, 1'b0, 1'b1, 0, 1'b0);

        for (int k = 0; k < 150; k++) begin
            rx = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            if ($urandom_range(0, 9) == 0)      ry = 32'd0;
            else if ($urandom_range(0, 3) == 0) ry = $urandom_range(1, 15);
            else if ($urandom_range(0, 7) == 0) ry = 32'hFFFF_FFFF;
            else                                ry = $urandom >> $urandom_range(0, 31);
            do_div($sformatf("rand%0d", k), rx, ry, 1'($urandom), 1'($urandom),
                   $urandom_range(0, 2), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
